pipelined_barrel_shifter: RTL and testbench
===========================================

// Module: pipelined_barrel_shifter
// PURPOSE
//   Parametrised, fully pipelined logarithmic barrel shifter for the ALU datapath.
//   Operand widths are parametrised. One register stage follows each of the log2(WIDTH) shift levels.
//   A valid/ready handshake is provided on both ends.
//   Supports logical left, logical right and arithmetic right shifts, plus optional rotate.
//   Sits beside the adder/logic units; the ALU result mux consumes dataOut when out_valid.
// PARAMETERS
//   WIDTH    32               operand/result width; power of two, >= 4
//   SHAMT_W  $clog2(WIDTH)    shift-amount bits taken from dataB (localparam, not overridable)
// PORTS
//   clk        in   1        clock, all state on rising edge
//   rst_n      in   1        asynchronous reset, active-low
//   flush      in   1        synchronous kill of all in-flight operations
//   in_valid   in   1        dataA/dataB/Signal valid
//   in_ready   out  1        pipeline accepts an operation this cycle
//   dataA      in   WIDTH    value to shift
//   dataB      in   WIDTH    shift amount; only dataB[SHAMT_W-1:0] used, upper bits ignored
//   Signal     in   6        op: SLL=6'b000000 SRL=6'b000010 SRA=6'b000011 ROR=6'b000110 ROL=6'b000111
//   out_valid  out  1        dataOut holds a completed result
//   out_ready  in   1        consumer takes the result this cycle
//   dataOut    out  WIDTH    shifted result
//   busy       out  1        OR of all stage valid bits
// BEHAVIOUR
//   - Reset (rst_n=0, async): all stage valids=0, out_valid=0, dataOut=0, busy=0.
//     in_ready=1 once reset is released.
//   - Stages S0..S(SHAMT_W-1); stage k shifts by 2^k when shamt bit k=1, else passes data through.
//   - Each stage registers: data, op, the remaining shamt bits, valid, and the original dataA MSB (SRA fill).
//   - Latency: SHAMT_W cycles from the accept edge to out_valid with no stall (5 for WIDTH=32).
//     Throughput: 1 op/cycle.
//   - Accept occurs when in_valid && in_ready. Complete occurs when out_valid && out_ready.
//   - Global stall: stall = out_valid && !out_ready; in_ready = !stall.
//     On stall, every stage register holds its value.
//     Bubbles are not compressed while stalled.
//   - dataOut/out_valid are stable while stalled; dataOut is don't-care when out_valid=0.
//   - Fill rules:
//       SLL fills LSBs with 0.
//       SRL fills MSBs with 0.
//       SRA fills MSBs with the original dataA[WIDTH-1].
//       ROR/ROL wrap.
//   - shamt=0: result = dataA for every op.
//     shamt=WIDTH-1 is the maximum; no larger amount is representable.
//   - Unsupported Signal code: result = 0, still passes through the pipeline with normal latency.
//   - flush=1: all valids cleared at the next edge, the output stage included.
//     flush has priority over stall.
//     An accept in the same cycle as flush is also discarded.
//     in_ready follows the stall rule during flush.
//   - Reset mid-operation: all in-flight ops are lost; no output is produced for them.
//   - busy=1 while any stage valid=1; the bench uses it to drain.
// CONFIGURATION
//   ROTATE_EN defined:     ROR and ROL supported. ROL by n is performed as ROR by (WIDTH-n) mod WIDTH.
//                          This negation is computed in the input stage; latency is unchanged.
//   ROTATE_EN not defined: codes 6'b000110 and 6'b000111 are unsupported (result 0).
//                          No wrap logic is instantiated.
// TESTING (WIDTH=32, latency 5)
//   1. SLL dataA=32'h0000_0001, dataB=31 -> dataOut=32'h8000_0000 exactly 5 cycles after accept.
//   2. SRA dataA=32'h8000_00F0, dataB=4 -> 32'hF800_000F.
//      SRL with the same operands -> 32'h0800_000F.
//   3. Back-to-back stream of 8 ops, out_ready held 0 for 3 cycles mid-stream.
//      Required: in_ready=0 for those cycles, no result lost or duplicated, results in issue order.
//   4. dataB=32'hFFFF_FFE3 (shamt=3), SLL of 32'h1 -> 32'h8 (upper dataB bits ignored).
//      shamt=0 on all ops -> dataA returned unchanged.
//   5. flush asserted with 3 ops in flight -> out_valid stays 0 and busy=0 next cycle.
//      Async rst_n pulse mid-stream -> all outputs 0 immediately.
//   6. ROTATE_EN: ROR 32'h0000_0001 by 1 -> 32'h8000_0000; ROL 32'h8000_0000 by 1 -> 32'h1.
//      Without ROTATE_EN both give 0.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined log2 barrel shifter (SLL/SRL/SRA, ROR/ROL when ROTATE_EN is defined)
module pipelined_barrel_shifter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dataOut,
   output logic             busy
);

   localparam int SHAMT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      OP_SLL = 2'd0,
      OP_SRL = 2'd1,
      OP_SRA = 2'd2,
      OP_ROR = 2'd3
   } op_t;

   // decoded input operation
   logic [WIDTH-1:0]   dec_data;
   op_t                dec_op;
   logic [SHAMT_W-1:0] dec_sh;
   logic               dec_msb;

   // per-level inputs and shifted outputs
   logic [WIDTH-1:0]   st_data [SHAMT_W];
   op_t                st_op   [SHAMT_W];
   logic [SHAMT_W-1:0] st_sh   [SHAMT_W];
   logic               st_msb  [SHAMT_W];
   logic [WIDTH-1:0]   data_d  [SHAMT_W];

   // stage registers
   logic [WIDTH-1:0]   data_q  [SHAMT_W];
   op_t                op_q    [SHAMT_W];
   logic [SHAMT_W-1:0] sh_q    [SHAMT_W];
   logic               msb_q   [SHAMT_W];
   logic [SHAMT_W-1:0] vld_q;

   logic stall;
   logic accept;
   logic unused_ok;

   // One shift level: moves d by amt when enabled, otherwise passes it through.
   function automatic logic [WIDTH-1:0] level_shift(
      input logic [WIDTH-1:0] d,
      input op_t              op,
      input logic             en,
      input logic             fill_bit,
      input int               amt
   );
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] fill_mask;
      fill_mask = ~({WIDTH{1'b1}} >> amt);
      r = d;
      if (en) begin
         case (op)
            OP_SLL:  r = d << amt;
            OP_SRL:  r = d >> amt;
            OP_SRA:  r = (d >> amt) | (fill_bit ? fill_mask : '0);
`ifdef ROTATE_EN
            OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
`endif
            default: r = d;
         endcase
      end
      return r;
   endfunction

   assign stall     = vld_q[SHAMT_W-1] && !out_ready;
   assign in_ready  = !stall;
   assign accept    = in_valid && in_ready;
   assign out_valid = vld_q[SHAMT_W-1];
   assign dataOut   = data_q[SHAMT_W-1];
   assign busy      = |vld_q;

   // Upper shift-amount bits and last-stage side-band are intentionally not consumed.
   assign unused_ok = ^{dataB[WIDTH-1:SHAMT_W], sh_q[SHAMT_W-1], op_q[SHAMT_W-1], msb_q[SHAMT_W-1]};

   // Decode the opcode; ROL becomes ROR by the negated amount, unknown codes carry a zero operand.
   always_comb begin
      dec_data = dataA;
      dec_op   = OP_SLL;
      dec_sh   = dataB[SHAMT_W-1:0];
      dec_msb  = dataA[WIDTH-1];
      case (Signal)
         6'b000000: dec_op = OP_SLL;
         6'b000010: dec_op = OP_SRL;
         6'b000011: dec_op = OP_SRA;
`ifdef ROTATE_EN
         6'b000110: dec_op = OP_ROR;
         6'b000111: begin
            dec_op = OP_ROR;
            dec_sh = '0 - dataB[SHAMT_W-1:0];
         end
`endif
         default: begin
            dec_data = '0;
            dec_op   = OP_SLL;
         end
      endcase
   end

   // Route each level's input from the decoder or the previous stage and apply its shift.
   always_comb begin
      st_data[0] = dec_data;
      st_op[0]   = dec_op;
      st_sh[0]   = dec_sh;
      st_msb[0]  = dec_msb;
      for (int k = 1; k < SHAMT_W; k++) begin
         st_data[k] = data_q[k-1];
         st_op[k]   = op_q[k-1];
         st_sh[k]   = sh_q[k-1];
         st_msb[k]  = msb_q[k-1];
      end
      for (int k = 0; k < SHAMT_W; k++) begin
         data_d[k] = level_shift(st_data[k], st_op[k], st_sh[k][k], st_msb[k], 1 << k);
      end
   end

   // Advance the pipeline unless the output is stalled; flush kills every valid bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int k = 0; k < SHAMT_W; k++) begin
            data_q[k] <= '0;
            op_q[k]   <= OP_SLL;
            sh_q[k]   <= '0;
            msb_q[k]  <= 1'b0;
         end
      end else begin
         if (flush) begin
            vld_q <= '0;
         end else if (!stall) begin
            vld_q <= {vld_q[SHAMT_W-2:0], accept};
         end
         if (!stall) begin
            for (int k = 0; k < SHAMT_W; k++) begin
               data_q[k] <= data_d[k];
               op_q[k]   <= st_op[k];
               sh_q[k]   <= st_sh[k];
               msb_q[k]  <= st_msb[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - randomized scoreboard bench for pipelined_barrel_shifter
module tb_pipelined_barrel_shifter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dataA;
   logic [W-1:0] dataB;
   logic [5:0]   Signal;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] dataOut;
   logic         busy;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   logic [5:0]   ops [5];
   bit           rnd_done;

   pipelined_barrel_shifter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .dataA(dataA), .dataB(dataB), .Signal(Signal),
      .out_valid(out_valid), .out_ready(out_ready),
      .dataOut(dataOut), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [5:0] sig, input logic [W-1:0] a, input logic [W-1:0] b);
      int s;
      s = int'(b % W);
      case (sig)
         6'b000000: return a << s;
         6'b000010: return a >> s;
         6'b000011: return W'($signed(a) >>> s);
`ifdef ROTATE_EN
         6'b000110: return (a >> s) | (a << (W - s));
         6'b000111: return (a << s) | (a >> (W - s));
`endif
         default:   return '0;
      endcase
   endfunction

   // scoreboard: expected results queued at accept, compared at completion
   always @(negedge clk) begin
      if (!rst_n || flush) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", out_valid, 1'b0);
            else check("result", dataOut, exp_q.pop_front());
         end
         if (in_valid && in_ready) exp_q.push_back(model(Signal, dataA, dataB));
      end
   end

   task automatic send(input logic [5:0] sig, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      Signal   = sig;
      dataA    = a;
      dataB    = b;
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) check("send_timeout", in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (busy && n < 500) begin
         @(posedge clk);
         #1 n++;
      end
      check("drain_busy", busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      ops[0] = 6'b000000; ops[1] = 6'b000010; ops[2] = 6'b000011;
      ops[3] = 6'b000110; ops[4] = 6'b000111;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      Signal = '0; dataA = '0; dataB = '0;
      #2;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_dataOut", dataOut, '0);
      check("rst_busy", busy, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_in_ready", in_ready, 1'b1);

      // latency: SLL 1 by 31, result completes on the 5th edge after accept
      Signal = 6'b000000; dataA = 32'h0000_0001; dataB = 32'd31; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         if (n < 5) check("lat_early", out_valid, 1'b0);
      end
      check("lat_valid", out_valid, 1'b1);
      check("lat_data", dataOut, 32'h8000_0000);
      drain();

      // SRA/SRL fill, upper dataB bits ignored, shamt=0, rotates
      send(6'b000011, 32'h8000_00F0, 32'd4);
      send(6'b000010, 32'h8000_00F0, 32'd4);
      send(6'b000000, 32'h0000_0001, 32'hFFFF_FFE3);
      for (int i = 0; i < 5; i++) send(ops[i], $urandom, $urandom & 32'hFFFF_FFE0);
      send(6'b000110, 32'h0000_0001, 32'd1);
      send(6'b000111, 32'h8000_0000, 32'd1);
      send(6'b000111, 32'h1234_5678, 32'd0);
      send(6'b000001, 32'hFFFF_FFFF, 32'd0);
      drain();

      // back-to-back stream with a 3-cycle output stall
      fork
         begin
            for (int i = 0; i < 8; i++) send(ops[$urandom_range(0, 4)], $urandom, $urandom);
         end
         begin
            repeat (7) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("stall_in_ready", in_ready, 1'b0);
               check("stall_out_valid", out_valid, 1'b1);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // randomized traffic with random backpressure
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [5:0] sig;
               logic [W-1:0] b;
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               case ($urandom_range(0, 6))
                  5:       sig = 6'($urandom);
                  6:       sig = 6'b000011;
                  default: sig = ops[$urandom_range(0, 4)];
               endcase
               case ($urandom_range(0, 5))
                  0:       b = 32'd0;
                  1:       b = 32'd31;
                  default: b = $urandom;
               endcase
               send(sig, $urandom | ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0), b);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // flush with three ops in flight
      for (int i = 0; i < 3; i++) send(ops[i], $urandom, $urandom);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_busy", busy, 1'b0);
      check("flush_out_valid", out_valid, 1'b0);
      repeat (7) @(posedge clk);
      #1 check("flush_quiet", out_valid, 1'b0);

      // accept coinciding with flush is discarded
      Signal = 6'b000000; dataA = 32'h1; dataB = 32'd1; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; flush = 1'b0;
      check("flush_accept_busy", busy, 1'b0);
      repeat (7) @(posedge clk);
      #1 check("flush_accept_quiet", out_valid, 1'b0);

      // asynchronous reset with a stalled, full pipeline
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(ops[$urandom_range(0, 2)], $urandom | 32'h1, 32'd1);
      check("pre_rst_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_dataOut", dataOut, '0);
      check("arst_busy", busy, 1'b0);
      check("arst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1 rst_n = 1'b1; out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1 check("post_rst_quiet", out_valid, 1'b0);

      drain();
      check("queue_left", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
